fp_addsub_arbiter: RTL

FP_ADDSUB_ARBITER -- requirements
Module: fp_addsub_arbiter

---
 rtl/riscv_types.sv | 15 +
 rtl/fp_addsub_arbiter_rr_arb2.sv | 33 +++
 rtl/fp_addsub_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/riscv_types.sv
// rtl/riscv_types.sv - shared fp add/sub request type and latency constant
package riscv_types;

   localparam int FP_ADDSUB_LAT   = 3;
   localparam int FP_ADDSUB_TAG_W = 5;

   typedef struct packed {
      logic                       add_sub;
      logic [31:0]                a;
      logic [31:0]                b;
      logic [2:0]                 rm;
      logic [FP_ADDSUB_TAG_W-1:0] tag;
   } fp_addsub_req_t;

endpackage

// File: rtl/fp_addsub_arbiter_rr_arb2.sv
// rtl/fp_addsub_arbiter_rr_arb2.sv - two-port arbiter (rr_arb2)
// FP_ADDSUB_RR_ARB_EN selects round-robin; otherwise port 0 has fixed priority.
module rr_arb2 (
`ifdef FP_ADDSUB_RR_ARB_EN
   input  logic       clk,
   input  logic       rst,
   input  logic       advance,
`endif
   input  logic [1:0] valid,
   output logic [1:0] grant
);

`ifdef FP_ADDSUB_RR_ARB_EN
   // last granted port; resets to 1 so port 0 wins the first contest
   logic last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last <= 1'b1;
      else if (advance)
         last <= grant[1];
   end

   always_comb begin
      grant = valid;
      if (valid == 2'b11)
         grant = last ? 2'b01 : 2'b10;
   end
`else
   assign grant = {valid[1] & ~valid[0], valid[0]};
`endif

endmodule

// File: rtl/fp_addsub_arbiter.sv
// rtl/fp_addsub_arbiter.sv - shares one pipelined fadd/fsub unit between two requesters
// Arbitration mode chosen by FP_ADDSUB_RR_ARB_EN (see rr_arb2).
module fp_addsub_arbiter
   import riscv_types::*;
#(
   parameter int NUM_REQ = 2,
   parameter int LAT     = FP_ADDSUB_LAT,
   parameter int TAG_W   = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_add_sub,
   input  logic [NUM_REQ-1:0][31:0]      req_a,
   input  logic [NUM_REQ-1:0][31:0]      req_b,
   input  logic [NUM_REQ-1:0][2:0]       req_rm,
   input  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag,
   input  logic                          flush,
   output logic                          u_p_start,
   output logic                          u_add_sub,
   output logic                          u_en,
   output logic [31:0]                   u_num1,
   output logic [31:0]                   u_num2,
   output logic [2:0]                    u_rm,
   output logic [2:0]                    u_clear,
   input  logic [31:0]                   u_sum,
   input  logic                          u_p_result,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [31:0]                   rsp_sum,
   output logic                          rsp_id,
   output logic [TAG_W-1:0]              rsp_tag,
   output logic                          busy
);

   logic [NUM_REQ-1:0]          grant;
   logic [NUM_REQ-1:0]          arb_valid;
   logic                        grant_en;
   fp_addsub_req_t              sel;
   logic                        sel_id;
   logic [LAT-1:0]              stg_valid;
   logic [LAT-1:0]              stg_id;
   logic [LAT-1:0][TAG_W-1:0]   stg_tag;

   // a stalled response freezes the unit; rst gating keeps req_ready low during reset
   assign rsp_valid = u_p_result & stg_valid[LAT-1];
   assign u_en      = ~(rsp_valid & ~rsp_ready);
   assign grant_en  = u_en & ~flush & rst;
   assign arb_valid = req_valid & {NUM_REQ{grant_en}};

   rr_arb2 u_arb (
`ifdef FP_ADDSUB_RR_ARB_EN
      .clk     (clk),
      .rst     (rst),
      .advance (u_p_start),
`endif
      .valid   (arb_valid),
      .grant   (grant)
   );

   assign req_ready = grant;
   assign u_p_start = |grant;

   always_comb begin
      sel    = '0;
      sel_id = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel.add_sub = req_add_sub[i];
            sel.a       = req_a[i];
            sel.b       = req_b[i];
            sel.rm      = req_rm[i];
            sel.tag     = FP_ADDSUB_TAG_W'(req_tag[i]);
            sel_id      = 1'(i);
         end
      end
   end

   assign u_num1    = sel.a;
   assign u_num2    = sel.b;
   assign u_add_sub = sel.add_sub;
   assign u_rm      = sel.rm;
   assign u_clear   = flush ? 3'b111 : 3'b000;

   // tracks which requester owns each unit stage; flush wins over a stall
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stg_valid <= '0;
         stg_id    <= '0;
         stg_tag   <= '0;
      end else if (flush) begin
         stg_valid <= '0;
      end else if (u_en) begin
         stg_valid <= {stg_valid[LAT-2:0], u_p_start};
         stg_id    <= {stg_id[LAT-2:0], sel_id};
         stg_tag   <= {stg_tag[LAT-2:0], TAG_W'(sel.tag)};
      end
   end

   assign rsp_sum = u_sum;
   assign rsp_id  = stg_id[LAT-1];
   assign rsp_tag = stg_tag[LAT-1];
   assign busy    = |stg_valid;

   a_track : assert property (@(posedge clk) disable iff (!rst)
      !(u_p_result && !stg_valid[LAT-1]));

endmodule
